// File: rtl/fft_power_unloader.sv
// fft_power_unloader
//   Drains complex FFT bins in order, computes power re^2 + im^2, right-shifts
//   by SHIFT, saturates to 32 bits and queues the result in a first-word-fall-
//   through FIFO that feeds a valid/ready stream tagged with bin index and
//   end-of-frame.
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   fft_ready_i          FFT result valid
//   x_re_i, x_im_i       signed real/imag part of the current bin
//   dl_busy_o            stall request back to the FFT
//   m_tdata_o            scaled, saturated power
//   m_tuser_o            bin index of m_tdata_o
//   m_tlast_o            high with the last bin of a frame
//   m_tvalid_o           output word valid
//   m_tready_i           sink accepts word
//   frame_cnt_o          completed frames (wraps)
//   overflow_o           sticky: a word reached a full FIFO and was dropped
module fft_power_unloader #(
   parameter int N          = 1024,
   parameter int FIFO_DEPTH = 16,
   parameter int SHIFT      = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 fft_ready_i,
   input  logic [31:0]          x_re_i,
   input  logic [31:0]          x_im_i,
   output logic                 dl_busy_o,
   output logic [31:0]          m_tdata_o,
   output logic [$clog2(N)-1:0] m_tuser_o,
   output logic                 m_tlast_o,
   output logic                 m_tvalid_o,
   input  logic                 m_tready_i,
   output logic [15:0]          frame_cnt_o,
   output logic                 overflow_o
);
   localparam int BW = $clog2(N);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic          last;
      logic [BW-1:0] bin;
      logic [31:0]   data;
   } word_t;

   // input side
   logic [BW-1:0] bin_q;
   logic [15:0]   frame_q;
   logic          accept;
   logic          bin_last;

   // S1: squares
   logic          s1_vld_q;
   logic [63:0]   s1_rr_q, s1_ii_q;
   logic [BW-1:0] s1_bin_q;
   logic          s1_last_q;

   // S2: saturated power
   logic          s2_vld_q;
   word_t         s2_word_q;

   // FIFO
   word_t         mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q;

   logic signed [63:0] re_s, im_s;
   logic [63:0]   rr_d, ii_d, p_d, q_d;
   logic [31:0]   sat_d;
   logic [CW:0]   occ;
   logic          full, pop, push;

   assign re_s = {{32{x_re_i[31]}}, x_re_i};
   assign im_s = {{32{x_im_i[31]}}, x_im_i};
   // Both squares are non-negative and below 2^63, so the low 64 bits are exact.
   assign rr_d = re_s * re_s;
   assign ii_d = im_s * im_s;

   assign p_d   = s1_rr_q + s1_ii_q;
   assign q_d   = p_d >> SHIFT;
   assign sat_d = (|q_d[63:32]) ? 32'hFFFF_FFFF : q_d[31:0];

   // Count words already in the FIFO plus those still in flight, so that any
   // sample accepted now is guaranteed a slot once the pipe drains.
   assign occ       = {1'b0, cnt_q} + (CW+1)'(s1_vld_q) + (CW+1)'(s2_vld_q);
   assign dl_busy_o = occ >= (CW+1)'(FIFO_DEPTH - 1);

   assign accept   = fft_ready_i & ~dl_busy_o;
   assign bin_last = bin_q == BW'(N - 1);

   assign full = cnt_q == CW'(FIFO_DEPTH);
   assign pop  = m_tvalid_o & m_tready_i;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push = s2_vld_q & (~full | pop);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (pop && !push)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         bin_q     <= '0;
         frame_q   <= '0;
         s1_vld_q  <= 1'b0;
         s1_rr_q   <= '0;
         s1_ii_q   <= '0;
         s1_bin_q  <= '0;
         s1_last_q <= 1'b0;
         s2_vld_q  <= 1'b0;
         s2_word_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (accept) begin
            bin_q <= bin_q + 1'b1;
            if (bin_last)
               frame_q <= frame_q + 1'b1;
         end
         s1_vld_q  <= accept;
         s1_rr_q   <= rr_d;
         s1_ii_q   <= ii_d;
         s1_bin_q  <= bin_q;
         s1_last_q <= bin_last;
         s2_vld_q  <= s1_vld_q;
         s2_word_q <= '{last: s1_last_q, bin: s1_bin_q, data: sat_d};
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         if (s2_vld_q && !push)
            ovf_q <= 1'b1;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (rstn && push)
         mem_q[wr_ptr_q] <= s2_word_q;
   end

   assign m_tvalid_o  = cnt_q != '0;
   assign m_tdata_o   = m_tvalid_o ? mem_q[rd_ptr_q].data : '0;
   assign m_tuser_o   = m_tvalid_o ? mem_q[rd_ptr_q].bin  : '0;
   assign m_tlast_o   = m_tvalid_o & mem_q[rd_ptr_q].last;
   assign frame_cnt_o = frame_q;
   assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_fft_power_unloader.sv
// Bench for fft_power_unloader: two instances (SHIFT=0 and SHIFT=16) share the
// same stimulus; each has its own scoreboard queue filled on accept and drained
// when its output handshakes.
module tb_fft_power_unloader;
   localparam int N  = 1024;
   localparam int BW = 10;

   logic clk = 1'b0, rstn = 1'b0, fft_ready = 1'b0, m_tready = 1'b0;
   logic [31:0] x_re = '0, x_im = '0;

   logic          busy [2];
   logic [31:0]   dd   [2];
   logic [BW-1:0] uu   [2];
   logic          ll   [2], vv [2], oo [2];
   logic [15:0]   ff   [2];

   always #5 clk = ~clk;

   fft_power_unloader #(.N(N), .FIFO_DEPTH(16), .SHIFT(0)) u_dut0 (
      .clk(clk), .rstn(rstn), .fft_ready_i(fft_ready), .x_re_i(x_re), .x_im_i(x_im),
      .dl_busy_o(busy[0]), .m_tdata_o(dd[0]), .m_tuser_o(uu[0]), .m_tlast_o(ll[0]),
      .m_tvalid_o(vv[0]), .m_tready_i(m_tready), .frame_cnt_o(ff[0]), .overflow_o(oo[0]));

   fft_power_unloader #(.N(N), .FIFO_DEPTH(16), .SHIFT(16)) u_dut1 (
      .clk(clk), .rstn(rstn), .fft_ready_i(fft_ready), .x_re_i(x_re), .x_im_i(x_im),
      .dl_busy_o(busy[1]), .m_tdata_o(dd[1]), .m_tuser_o(uu[1]), .m_tlast_o(ll[1]),
      .m_tvalid_o(vv[1]), .m_tready_i(m_tready), .frame_cnt_o(ff[1]), .overflow_o(oo[1]));

   typedef struct {
      logic [31:0]   data;
      logic [BW-1:0] bin;
      logic          last;
   } exp_t;

   exp_t sbq [2][$];
   int   n_chk = 0, n_err = 0;
   int   exp_bin = 0, exp_frames = 0;
   logic busy_seen = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pwr(input logic [31:0] re, input logic [31:0] im, input int sh);
      logic signed [63:0] r, i;
      logic [63:0] p, q;
      r = {{32{re[31]}}, re};
      i = {{32{im[31]}}, im};
      p = r * r + i * i;
      q = p >> sh;
      return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
   endfunction

   // scoreboard monitor, sampled on the falling edge
   logic          pv [2];
   logic [31:0]   pd [2];
   logic          pr;
   initial begin pv[0] = 0; pv[1] = 0; pr = 0; end

   always @(negedge clk) begin
      if (!rstn) begin
         pv[0] = 0; pv[1] = 0; pr = 0;
      end else begin
         chk("busy_eq", busy[0], busy[1]);
         if (busy[1]) busy_seen = 1'b1;
         for (int k = 0; k < 2; k++) begin
            exp_t e;
            if (pv[k] && !pr) begin
               chk($sformatf("hold_v%0d", k), vv[k], 1);
               chk($sformatf("hold_d%0d", k), dd[k], pd[k]);
            end
            if (vv[k] && m_tready) begin
               if (sbq[k].size() == 0)
                  chk($sformatf("unexp%0d", k), 1, 0);
               else begin
                  e = sbq[k].pop_front();
                  chk($sformatf("data%0d", k), dd[k], e.data);
                  chk($sformatf("bin%0d", k),  uu[k], e.bin);
                  chk($sformatf("last%0d", k), ll[k], e.last);
               end
            end
            pv[k] = vv[k];
            pd[k] = dd[k];
         end
         pr = m_tready;
      end
   end

   task automatic push_exp(input logic [31:0] re, input logic [31:0] im);
      for (int k = 0; k < 2; k++)
         sbq[k].push_back('{data: pwr(re, im, k * 16), bin: BW'(exp_bin), last: exp_bin == N - 1});
      if (exp_bin == N - 1) exp_frames++;
      exp_bin = (exp_bin + 1) % N;
   endtask

   // Present a sample, hold it while the DUT is busy, return after the accept edge.
   task automatic send(input logic [31:0] re, input logic [31:0] im);
      int t = 0;
      fft_ready = 1'b1; x_re = re; x_im = im;
      while (busy[1] && t < 300) begin @(posedge clk); #1; t++; end
      if (t >= 300) begin
         chk("send_timeout", 1, 0);
         fft_ready = 1'b0;
         return;
      end
      push_exp(re, im);
      @(posedge clk); #1;
      fft_ready = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sbq[0].size() != 0 || sbq[1].size() != 0) && t < 3000) begin @(posedge clk); #1; t++; end
      chk("drain", sbq[0].size() + sbq[1].size(), 0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sbq[0].delete(); sbq[1].delete();
      exp_bin = 0; exp_frames = 0;
      fft_ready = 1'b0;
      rstn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: reset held with the FFT offering data
      fft_ready = 1'b1; x_re = 32'd5; x_im = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_valid", vv[k], 0);
         chk("rst_data",  dd[k], 0);
         chk("rst_user",  uu[k], 0);
         chk("rst_last",  ll[k], 0);
         chk("rst_busy",  busy[k], 0);
         chk("rst_frame", ff[k], 0);
         chk("rst_ovf",   oo[k], 0);
      end
      fft_ready = 1'b0;
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_noaccept", vv[1], 0);

      // 2: single bin, latency of exactly two edges
      m_tready = 1'b0;
      send(32'd3, 32'hFFFF_FFFC);
      chk("lat_t0", vv[0], 0);
      @(posedge clk); #1;
      chk("lat_t1", vv[0], 0);
      @(posedge clk); #1;
      chk("lat_t2", vv[0], 1);
      chk("single_data", dd[0], 25);
      chk("single_user", uu[0], 0);
      m_tready = 1'b1;
      @(posedge clk); #1;
      chk("single_popped", vv[0], 0);

      // 3: saturation and mid-range scaling
      m_tready = 1'b0;
      send(32'h8000_0000, 32'h8000_0000);
      send(32'h0000_8000, 32'h0000_8000);
      repeat (3) @(posedge clk);
      #1;
      chk("sat16", dd[1], 32'hFFFF_FFFF);
      chk("sat0",  dd[0], 32'hFFFF_FFFF);
      m_tready = 1'b1;
      @(posedge clk); #1;
      chk("mid16", dd[1], 32'h0000_8000);
      chk("mid0",  dd[0], 32'h8000_0000);
      drain();

      // 4: full frame, sink always ready
      do_reset();
      m_tready = 1'b1;
      @(posedge clk); #1;
      busy_seen = 1'b0;
      for (int i = 0; i < N; i++)
         send(32'(i * 1000 - 500000), 32'(i * 37));
      drain();
      chk("frame_cnt", ff[1], 1);
      chk("frame_exp", ff[0], 32'(exp_frames));
      chk("no_busy", busy_seen, 0);

      // 5: back-pressure
      do_reset();
      m_tready = 1'b0;
      fork
         for (int i = 0; i < 40; i++)
            send(32'($urandom), 32'($urandom));
         begin
            int t = 0;
            #1;
            while (!busy[1] && t < 100) begin @(posedge clk); #2; t++; end
            chk("busy_rise", busy[1], 1);
            chk("occ_at_busy", sbq[1].size(), 15);
            repeat (20) @(posedge clk);
            #2;
            chk("occ_stall", sbq[1].size(), 15);
            chk("vld_stall", vv[1], 1);
            chk("ovf_stall", oo[1], 0);
            m_tready = 1'b1;
         end
      join
      drain();
      chk("ovf_after", oo[1], 0);

      // 6: reset at bin 500 of the second frame
      m_tready = 1'b1;
      for (int i = 0; i < N - 40 + 500; i++)
         send(32'(i), 32'(-i));
      chk("pre_rst_frame", ff[1], 1);
      fft_ready = 1'b1;
      do_reset();
      chk("mid_rst_valid", vv[1], 0);
      chk("mid_rst_frame", ff[1], 0);
      m_tready = 1'b0;
      send(32'd10, 32'd20);
      repeat (2) @(posedge clk);
      #1;
      chk("restart_user", uu[1], 0);
      chk("restart_data", dd[0], 500);
      m_tready = 1'b1;
      for (int i = 0; i < 5; i++)
         send(32'(i + 1), 32'(i + 2));
      drain();
      chk("restart_frame", ff[1], 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
